// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port sequencer of the multicycle MIPS core.
package mips_mem_pkg;

    localparam int MEM_WORDS_DEFAULT = 513;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        SRC_FETCH,
        SRC_DATA
    } src_t;

endpackage

// File: rtl/mem_req_arbiter.sv
// Combinational priority select between the instruction-fetch and load/store requesters.
module mem_req_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_pc,
    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic              o_grant,
    output logic              o_sel_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic [DATA_W-1:0] o_wdata
);

    logic w_pick_data;

    generate
        if (DATA_FIRST) begin : g_data_first
            assign w_pick_data = i_data_req;
        end else begin : g_fetch_first
            assign w_pick_data = i_data_req && !i_fetch_req;
        end
    endgenerate

    // A fetch is always presented as a read with no write data, whatever data_we says.
    assign o_grant    = i_fetch_req | i_data_req;
    assign o_sel_data = w_pick_data;
    assign o_addr     = w_pick_data ? i_data_addr : i_fetch_pc;
    assign o_we       = w_pick_data & i_data_we;
    assign o_wdata    = w_pick_data ? i_data_wdata : '0;

endmodule

// File: rtl/mem_port_sequencer.sv
// Serialises fetch and load/store requests onto the single Memory port and holds the
// instruction register (Instr) and memory data register (MemDataReg).
module mem_port_sequencer
    import mips_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ack,
    output logic              fetch_done,
    output logic [DATA_W-1:0] Instr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic              data_done,
    output logic [DATA_W-1:0] MemDataReg,
    output logic              access_err,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_MemData
);

    state_t            r_state;
    src_t              r_tag;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_mdr;
    logic              r_fetch_done;
    logic              r_data_done;
    logic              r_err;

    logic              w_grant;
    logic              w_sel_data;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_accept;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdata;

    mem_req_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DATA_FIRST (DATA_FIRST)
    ) u_arbiter (
        .i_fetch_req  (fetch_req),
        .i_fetch_pc   (fetch_pc),
        .i_data_req   (data_req),
        .i_data_we    (data_we),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .o_grant      (w_grant),
        .o_sel_data   (w_sel_data),
        .o_addr       (w_sel_addr),
        .o_we         (w_sel_we),
        .o_wdata      (w_sel_wdata)
    );

    assign w_accept   = (r_state == IDLE) && w_grant && !Reset;
    assign w_in_range = (r_addr < ADDR_W'(MEM_WORDS));
    assign w_rdata    = w_in_range ? mem_MemData : '0;

    assign fetch_ack = w_accept && !w_sel_data;
    assign data_ack  = w_accept && w_sel_data;

    // The write strobe is gated by Reset so a store interrupted mid-access never lands.
    assign mem_writeEnable = (r_state == ACCESS) && (r_tag == SRC_DATA) && r_we
                             && w_in_range && !Reset;
    assign mem_Address     = r_addr;
    assign mem_writeData   = r_wdata;

    assign Instr      = r_instr;
    assign MemDataReg = r_mdr;
    assign fetch_done = r_fetch_done;
    assign data_done  = r_data_done;
    assign access_err = r_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_tag        <= SRC_FETCH;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_instr      <= '0;
            r_mdr        <= '0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_tag   <= w_sel_data ? SRC_DATA : SRC_FETCH;
                        r_addr  <= w_sel_addr;
                        r_we    <= w_sel_we;
                        r_wdata <= w_sel_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        if (r_tag == SRC_FETCH) begin
                            r_instr <= w_rdata;
                        end else begin
                            r_mdr <= w_rdata;
                        end
                    end
                    r_fetch_done <= (r_tag == SRC_FETCH);
                    r_data_done  <= (r_tag == SRC_DATA);
                    r_err        <= !w_in_range;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: attached word memory, timeline reference model, directed and random traffic.
module tb_mem_port_sequencer;

    localparam int MEM_WORDS = 513;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ack;
    logic        fetch_done;
    logic [31:0] Instr;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ack;
    logic        data_done;
    logic [31:0] MemDataReg;
    logic        access_err;
    logic [31:0] mem_Address;
    logic [31:0] mem_writeData;
    logic        mem_writeEnable;
    logic [31:0] mem_MemData;

    logic [31:0] mem_dev [0:1023];
    logic [31:0] ref_mem [0:1023];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned tcyc = 0;
    int          we_cnt = 0;
    int          ddone_cnt = 0;
    int          txn_no = 0;

    mem_port_sequencer #(
        .DATA_W(32), .ADDR_W(32), .MEM_WORDS(MEM_WORDS), .DATA_FIRST(1'b1)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack),
        .fetch_done(fetch_done), .Instr(Instr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_done(data_done),
        .MemDataReg(MemDataReg), .access_err(access_err),
        .mem_Address(mem_Address), .mem_writeData(mem_writeData),
        .mem_writeEnable(mem_writeEnable), .mem_MemData(mem_MemData)
    );

    initial forever #5 Clk = ~Clk;
    initial forever begin
        @(posedge Clk);
        tcyc++;
    end

    assign mem_MemData = mem_dev[mem_Address[9:0]];
    always @(posedge Clk) begin
        if (mem_writeEnable) mem_dev[mem_Address[9:0]] = mem_writeData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, tcyc, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s cyc=%0d: wait bound expired", name, tcyc);
    endtask

    // ---------------- reference model: each accepted request owns cycles start..start+2
    typedef struct {
        bit          valid;
        int unsigned start;
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    initial begin
        txn_t        inf;
        int unsigned next_free;
        bit          zero_next;
        logic [31:0] exp_instr, exp_mdr, rd;
        bit          e_fack, e_dack, e_fdone, e_ddone, e_err, e_we, pick_data, in_r;
        inf = '{valid: 1'b0, start: 0, is_data: 1'b0, we: 1'b0, addr: '0, wdata: '0};
        next_free = 0;
        zero_next = 1'b1;
        exp_instr = '0;
        exp_mdr   = '0;
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            {e_fack, e_dack, e_fdone, e_ddone, e_err, e_we} = '0;
            if (zero_next) begin
                exp_instr = '0;
                exp_mdr   = '0;
                zero_next = 1'b0;
            end
            if (inf.valid && tcyc == inf.start + 2) begin
                in_r = (inf.addr < MEM_WORDS);
                rd   = in_r ? ref_mem[inf.addr[9:0]] : 32'h0;
                e_fdone = !inf.is_data;
                e_ddone = inf.is_data;
                e_err   = !in_r;
                if (!inf.is_data) exp_instr = rd;
                else if (!inf.we) exp_mdr = rd;
                inf.valid = 1'b0;
                txn_no++;
                $display("txn %0d cyc=%0d %s addr=%0d we=%0b wdata=%h err=%0b rdata=%h",
                         txn_no, tcyc, inf.is_data ? "DATA " : "FETCH", inf.addr, inf.we,
                         inf.wdata, e_err, rd);
            end
            if (inf.valid && tcyc == inf.start + 1) begin
                if (Reset) begin
                    inf.valid = 1'b0;
                end else begin
                    check("mem_Address", mem_Address, inf.addr);
                    if (inf.is_data && inf.we) begin
                        check("mem_writeData", mem_writeData, inf.wdata);
                        if (inf.addr < MEM_WORDS) begin
                            e_we = 1'b1;
                            ref_mem[inf.addr[9:0]] = inf.wdata;
                        end
                    end
                end
            end
            if (Reset) begin
                next_free = tcyc + 1;
                zero_next = 1'b1;
            end else if (tcyc >= next_free && (fetch_req || data_req)) begin
                pick_data = data_req;
                e_fack = !pick_data;
                e_dack = pick_data;
                inf = '{valid: 1'b1, start: tcyc, is_data: pick_data,
                        we: pick_data ? data_we : 1'b0,
                        addr: pick_data ? data_addr : fetch_pc,
                        wdata: data_wdata};
                next_free = tcyc + 3;
            end
            if (mem_writeEnable === 1'b1) we_cnt++;
            if (data_done === 1'b1) ddone_cnt++;
            check("fetch_ack", {31'b0, fetch_ack}, {31'b0, e_fack});
            check("data_ack", {31'b0, data_ack}, {31'b0, e_dack});
            check("fetch_done", {31'b0, fetch_done}, {31'b0, e_fdone});
            check("data_done", {31'b0, data_done}, {31'b0, e_ddone});
            check("access_err", {31'b0, access_err}, {31'b0, e_err});
            check("mem_writeEnable", {31'b0, mem_writeEnable}, {31'b0, e_we});
            check("Instr", Instr, exp_instr);
            check("MemDataReg", MemDataReg, exp_mdr);
        end
    end

    // ---------------- requester tasks (entered and left aligned to the clock)
    task automatic run_fetch(input logic [31:0] pc, input int max_wait,
                             output bit acked, output int ack_c, output int done_c);
        int n;
        bit got;
        acked = 1'b0; ack_c = -1; done_c = -1;
        @(posedge Clk); #1;
        fetch_pc = pc;
        fetch_req = 1'b1;
        n = 0;
        while (!acked && n < max_wait) begin
            @(negedge Clk);
            if (fetch_ack) begin acked = 1'b1; ack_c = int'(tcyc); end
            @(posedge Clk); #1;
            n++;
        end
        fetch_req = 1'b0;
        if (!acked) begin
            if (max_wait >= 30) note_timeout("fetch_ack_wait");
            return;
        end
        got = 1'b0; n = 0;
        while (!got && n < 30) begin
            @(negedge Clk);
            if (fetch_done) begin got = 1'b1; done_c = int'(tcyc); end
            n++;
        end
        if (!got) note_timeout("fetch_done_wait");
    endtask

    task automatic run_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int max_wait, output bit acked, output int ack_c,
                            output int done_c, output logic err);
        int n;
        bit got;
        acked = 1'b0; ack_c = -1; done_c = -1; err = 1'bx;
        @(posedge Clk); #1;
        data_we = we;
        data_addr = addr;
        data_wdata = wdata;
        data_req = 1'b1;
        n = 0;
        while (!acked && n < max_wait) begin
            @(negedge Clk);
            if (data_ack) begin acked = 1'b1; ack_c = int'(tcyc); end
            @(posedge Clk); #1;
            n++;
        end
        data_req = 1'b0;
        data_we = 1'($urandom);
        if (!acked) begin
            if (max_wait >= 30) note_timeout("data_ack_wait");
            return;
        end
        got = 1'b0; n = 0;
        while (!got && n < 30) begin
            @(negedge Clk);
            if (data_done) begin got = 1'b1; done_c = int'(tcyc); err = access_err; end
            n++;
        end
        if (!got) note_timeout("data_done_wait");
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'($urandom_range(128, 135));
            2:       return 32'($urandom_range(505, 520));
            default: return 32'($urandom_range(0, 600));
        endcase
    endfunction

    // ---------------- stimulus
    initial begin
        bit   ak, ak2;
        int   a1, d1, a2, d2, w0, dd0, n, mism;
        logic e1;
        for (int i = 0; i < 1024; i++) begin
            mem_dev[i] = '0;
            ref_mem[i] = '0;
        end
        mem_dev[0] = 32'd8;   ref_mem[0] = 32'd8;
        mem_dev[1] = 32'd1;   ref_mem[1] = 32'd1;
        mem_dev[2] = 32'd1;   ref_mem[2] = 32'd1;
        mem_dev[128] = 32'h8c030000; ref_mem[128] = 32'h8c030000;
        mem_dev[132] = 32'h8c040001; ref_mem[132] = 32'h8c040001;

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_mem_Address", mem_Address, 32'h0);
        check("rst_Instr", Instr, 32'h0);
        check("rst_MemDataReg", MemDataReg, 32'h0);
        check("rst_writeEnable", {31'b0, mem_writeEnable}, 32'h0);

        w0 = we_cnt;
        run_fetch(32'd128, 30, ak, a1, d1);
        check("fetch128_latency", 32'(d1 - a1), 32'd2);
        check("fetch128_Instr", Instr, 32'h8c030000);
        check("fetch128_no_write", 32'(we_cnt - w0), 32'd0);

        run_data(1'b0, 32'd0, 32'h0, 30, ak, a1, d1, e1);
        check("load0_latency", 32'(d1 - a1), 32'd2);
        check("load0_MemDataReg", MemDataReg, 32'd8);
        check("load0_err", {31'b0, e1}, 32'h0);

        w0 = we_cnt;
        run_data(1'b1, 32'd6, 32'hD, 30, ak, a1, d1, e1);
        check("store6_pulses", 32'(we_cnt - w0), 32'd1);
        run_data(1'b0, 32'd6, 32'h0, 30, ak, a1, d1, e1);
        check("load6_MemDataReg", MemDataReg, 32'h0000000D);

        fork
            run_fetch(32'd132, 30, ak, a1, d1);
            run_data(1'b0, 32'd1, 32'h0, 30, ak2, a2, d2, e1);
        join
        check("both_fetch_after_data", 32'(a1 - a2), 32'd3);
        check("both_MemDataReg", MemDataReg, 32'd1);
        check("both_Instr", Instr, 32'h8c040001);

        w0 = we_cnt;
        run_data(1'b1, 32'd600, 32'hBEEF, 30, ak, a1, d1, e1);
        check("store600_no_write", 32'(we_cnt - w0), 32'd0);
        check("store600_err", {31'b0, e1}, 32'd1);
        run_data(1'b0, 32'd600, 32'h0, 30, ak, a1, d1, e1);
        check("load600_MemDataReg", MemDataReg, 32'h0);
        check("load600_err", {31'b0, e1}, 32'd1);

        // Store interrupted by Reset while the access is on the bus.
        @(posedge Clk); #1;
        data_we = 1'b1; data_addr = 32'd6; data_wdata = 32'h55; data_req = 1'b1;
        ak = 1'b0; n = 0;
        while (!ak && n < 30) begin
            @(negedge Clk);
            if (data_ack) ak = 1'b1;
            else begin @(posedge Clk); #1; end
            n++;
        end
        if (!ak) note_timeout("rst_store_ack_wait");
        dd0 = ddone_cnt;
        @(posedge Clk); #1;
        data_req = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_access_writeEnable", {31'b0, mem_writeEnable}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("rst_access_no_done", 32'(ddone_cnt - dd0), 32'd0);
        check("rst_access_mem6", mem_dev[6], 32'h0000000D);

        fork
            begin
                bit   fk;
                int   fa, fd;
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 2)) @(posedge Clk);
                    run_fetch(rand_addr(), 30, fk, fa, fd);
                end
            end
            begin
                bit   dk;
                int   da, dd;
                logic de;
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 2)) @(posedge Clk);
                    run_data(1'($urandom), rand_addr(), $urandom,
                             ($urandom_range(0, 7) == 0) ? 1 : 30, dk, da, dd, de);
                end
            end
        join

        repeat (4) @(posedge Clk);
        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem_dev[i] !== ref_mem[i]) mism++;
        end
        check("final_memory_mismatch_words", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
